// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-granular arbiter sharing one fifo write port among N producers.
// Optional per-requester beat counters on stat_beats_o when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arb #(
    parameter int WIDTH    = 24,
    parameter int N        = 2,
    parameter int BURST    = 16,
    parameter int IDLE_MAX = 8,
    localparam int TAGW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [N-1:0]         req_val_i,
    input  logic [N*WIDTH-1:0]   req_data_i,
    input  logic [N-1:0]         req_last_i,
    output logic [N-1:0]         req_rdy_o,
    output logic                 out_val_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [TAGW-1:0]      out_tag_o,
    input  logic                 out_rdy_i,
    output logic                 busy_o
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N*32-1:0]      stat_beats_o
`endif
);

    localparam int BCW = (BURST > 0) ? $clog2(BURST + 1) : 1;
    localparam int ICW = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;

    // Handshake: a beat moves only when out_val_o && out_rdy_i; the granted
    // requester sees out_rdy_i on its req_rdy_o, and valid/data must stay put until then.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [TAGW-1:0] gnt, last_gnt, pick, idx;
    logic [BCW-1:0]  beat_cnt;
    logic [ICW-1:0]  idle_cnt;
    logic            found, beat, burst_hit, idle_hit, rel;

    // Round-robin scan starting just after the previous grantee.
    always_comb begin
        pick  = last_gnt;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = TAGW'((int'(last_gnt) + i) % N);
            if (!found && req_val_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        beat      = (state == S_GRANT) && req_val_i[gnt] && out_rdy_i;
        burst_hit = (BURST > 0) && beat && (int'(beat_cnt) + 1 >= BURST);
        idle_hit  = (IDLE_MAX > 0) && (state == S_GRANT) && !req_val_i[gnt] && out_rdy_i
                    && (int'(idle_cnt) + 1 >= IDLE_MAX);
        rel       = (beat && req_last_i[gnt]) || burst_hit || idle_hit;
    end

    always_comb begin
        state_next = state;
        out_val_o  = 1'b0;
        out_data_o = '0;
        req_rdy_o  = '0;
        out_tag_o  = gnt;
        busy_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req_val_i) state_next = S_GRANT;
            end
            S_GRANT: begin
                busy_o     = 1'b1;
                out_val_o  = req_val_i[gnt];
                out_data_o = req_data_i[int'(gnt)*WIDTH +: WIDTH];
                for (int k = 0; k < N; k++) begin
                    req_rdy_o[k] = (gnt == TAGW'(k)) && out_rdy_i;
                end
                if (rel) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            gnt      <= '0;
            last_gnt <= TAGW'(N - 1);
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (|req_val_i) begin
                gnt      <= pick;
                beat_cnt <= '0;
                idle_cnt <= '0;
            end
        end else begin
            if (rel) last_gnt <= gnt;
            if (beat && beat_cnt != {BCW{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
            // Fifo-full cycles neither count as idle nor break an idle run.
            if (req_val_i[gnt])                               idle_cnt <= '0;
            else if (out_rdy_i && idle_cnt != {ICW{1'b1}})    idle_cnt <= idle_cnt + 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0] stat_cnt [N];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int k = 0; k < N; k++) stat_cnt[k] <= '0;
        end else if (beat) begin
            stat_cnt[gnt] <= stat_cnt[gnt] + 32'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) stat_beats_o[k*32 +: 32] = stat_cnt[k];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: vector table, hand sequences, and a randomized run against a transaction model.
module tb_fifo_wr_arb;

    localparam int WIDTH    = 24;
    localparam int N        = 2;
    localparam int BURST    = 16;
    localparam int IDLE_MAX = 8;
    localparam int TAGW     = 1;
    localparam logic [WIDTH-1:0] D0 = 24'hA0A0A0;
    localparam logic [WIDTH-1:0] D1 = 24'h5B5B5B;

    logic                 clk_i = 1'b0;
    logic                 arst_i;
    logic [N-1:0]         req_val_i;
    logic [N*WIDTH-1:0]   req_data_i;
    logic [N-1:0]         req_last_i;
    logic [N-1:0]         req_rdy_o;
    logic                 out_val_o;
    logic [WIDTH-1:0]     out_data_o;
    logic [TAGW-1:0]      out_tag_o;
    logic                 out_rdy_i;
    logic                 busy_o;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*32-1:0]      stat_beats_o;
`endif

    fifo_wr_arb #(.WIDTH(WIDTH), .N(N), .BURST(BURST), .IDLE_MAX(IDLE_MAX)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .req_val_i(req_val_i), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_rdy_o(req_rdy_o), .out_val_o(out_val_o),
        .out_data_o(out_data_o), .out_tag_o(out_tag_o), .out_rdy_i(out_rdy_i),
        .busy_o(busy_o)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stat_beats_o(stat_beats_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        arst_i     = 1'b1;
        req_val_i  = '0;
        req_last_i = '0;
        req_data_i = '0;
        out_rdy_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        arst_i = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]    val;
        logic [N-1:0]    last;
        logic            rdy;
        logic            exp_val;
        logic [N-1:0]    exp_rdy;
        logic [TAGW-1:0] exp_tag;
        logic            exp_busy;
    } vec_t;

    vec_t vecs[12];

    // Random-run producers and transaction model
    logic [WIDTH-1:0] exp_q [N][$];
    bit               have[N];
    logic [WIDTH-1:0] cur_d[N];
    bit               cur_l[N];
    int               gap[N], rem[N], seq[N];
    bit               stop_gen;
    bit               m_busy;
    int               m_tag, m_last, m_beats, m_idle;

    task automatic drive_producers(input int rdy_mode, input bit tog);
        for (int k = 0; k < N; k++) begin
            if (!have[k]) begin
                if (gap[k] > 0) gap[k]--;
                else if (!stop_gen) begin
                    if (rem[k] == 0) rem[k] = $urandom_range(1, 20);
                    cur_d[k] = {4'(k), 20'(seq[k])};
                    seq[k]++;
                    cur_l[k] = (rem[k] == 1);
                    rem[k]--;
                    have[k] = 1'b1;
                    exp_q[k].push_back(cur_d[k]);
                    if ($urandom_range(0, 7) == 0) gap[k] = $urandom_range(1, 12);
                end
            end
            req_val_i[k]                 = have[k];
            req_data_i[k*WIDTH +: WIDTH] = cur_d[k];
            req_last_i[k]                = have[k] && cur_l[k];
        end
        case (rdy_mode)
            0:       out_rdy_i = ($urandom_range(0, 3) != 0);
            1:       out_rdy_i = tog;
            default: out_rdy_i = 1'b1;
        endcase
    endtask

    task automatic model_step();
        logic [N-1:0] e_rdy;
        bit           released;
        check("rnd_busy", busy_o, m_busy);
        released = 1'b0;
        if (m_busy) begin
            e_rdy        = '0;
            e_rdy[m_tag] = out_rdy_i;
            check("rnd_tag", out_tag_o, m_tag);
            check("rnd_val", out_val_o, req_val_i[m_tag]);
            check("rnd_rdy", req_rdy_o, e_rdy);
            if (req_val_i[m_tag] && out_rdy_i) begin
                if (exp_q[m_tag].size() == 0) check("rnd_unexpected_beat", 1, 0);
                else check("rnd_data", out_data_o, exp_q[m_tag].pop_front());
                m_beats++;
                if (req_last_i[m_tag] || m_beats == BURST) released = 1'b1;
            end else if (!req_val_i[m_tag] && out_rdy_i) begin
                m_idle++;
                if (m_idle == IDLE_MAX) released = 1'b1;
            end
            if (req_val_i[m_tag]) m_idle = 0;
            if (released) begin
                m_busy = 1'b0;
                m_last = m_tag;
            end
        end else begin
            check("rnd_idle_val", out_val_o, 0);
            check("rnd_idle_rdy", req_rdy_o, 0);
            if (|req_val_i) begin
                for (int i = N; i >= 1; i--) begin
                    if (req_val_i[(m_last + i) % N]) m_tag = (m_last + i) % N;
                end
                m_busy  = 1'b1;
                m_beats = 0;
                m_idle  = 0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (req_val_i[k] && req_rdy_o[k]) have[k] = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
        vecs[4]  = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        vecs[5]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1};
        vecs[7]  = '{2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        vecs[8]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[9]  = '{2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};

        // Reset values
        arst_i = 1'b1;
        req_val_i = '0; req_last_i = '0; req_data_i = '0; out_rdy_i = 1'b0;
        #2;
        check("rst_val", out_val_o, 0);
        check("rst_rdy", req_rdy_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tag", out_tag_o, 0);
        check("rst_data", out_data_o, 0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("rst_stats", stat_beats_o, 0);
`endif

        // Vector table
        do_reset();
        for (int r = 0; r < 12; r++) begin
            req_val_i  = vecs[r].val;
            req_last_i = vecs[r].last;
            out_rdy_i  = vecs[r].rdy;
            req_data_i = {D1, D0};
            @(negedge clk_i);
            check($sformatf("vec%0d_val", r), out_val_o, vecs[r].exp_val);
            check($sformatf("vec%0d_rdy", r), req_rdy_o, vecs[r].exp_rdy);
            check($sformatf("vec%0d_tag", r), out_tag_o, vecs[r].exp_tag);
            check($sformatf("vec%0d_busy", r), busy_o, vecs[r].exp_busy);
            check($sformatf("vec%0d_data", r), out_data_o,
                  vecs[r].exp_busy ? (vecs[r].exp_tag ? D1 : D0) : '0);
            next_cycle();
        end

        // Mid-burst reset drops the grant at once; req0 wins first afterwards
        do_reset();
        req_val_i = 2'b11; req_data_i = {D1, D0}; out_rdy_i = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        arst_i = 1'b1;
        #1;
        check("midrst_val", out_val_o, 0);
        check("midrst_rdy", req_rdy_o, 0);
        check("midrst_busy", busy_o, 0);
        next_cycle();
        arst_i = 1'b0;
        @(negedge clk_i);
        check("postrst_idle", busy_o, 0);
        next_cycle();
        @(negedge clk_i);
        check("postrst_busy", busy_o, 1);
        check("postrst_tag", out_tag_o, 0);

        // Full bursts: 16 beats per grant, one bubble between, alternating tags
        do_reset();
        req_val_i = 2'b11; req_data_i = {D1, D0}; out_rdy_i = 1'b1;
        for (int c = 0; c < 102; c++) begin
            @(negedge clk_i);
            if (c == 0 || (c - 1) % 17 == 16) begin
                check("burst_bubble", {busy_o, out_val_o}, 2'b00);
            end else begin
                check("burst_val", out_val_o, 1);
                check("burst_tag", out_tag_o, ((c - 1) / 17) % 2);
            end
            next_cycle();
        end
        req_val_i = 2'b00;
        @(negedge clk_i);
        check("burst_end_idle", busy_o, 0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("stats_48_48", stat_beats_o, {32'd48, 32'd48});
`endif

        // Last on beat 5 releases early; next grant gets a full fresh burst
        do_reset();
        req_val_i = 2'b11; req_data_i = {D1, D0}; out_rdy_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            req_last_i = (c == 5) ? 2'b01 : 2'b00;
            @(negedge clk_i);
            check("last5_busy", busy_o, !(c == 0 || c == 6 || c == 23));
            if (!(c == 0 || c == 6 || c == 23)) check("last5_tag", out_tag_o, (c < 6) ? 0 : 1);
            next_cycle();
        end
        req_val_i = 2'b00; req_last_i = 2'b00;

        // Idle timeout after valid drops, then fifo-full holding the grant
        do_reset();
        req_val_i = 2'b01; req_data_i = {D1, D0}; out_rdy_i = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("idle_beat", out_val_o && busy_o, 1);
            next_cycle();
        end
        req_val_i = 2'b00;
        for (int c = 0; c < IDLE_MAX; c++) begin
            @(negedge clk_i);
            check("idle_hold", busy_o, 1);
            next_cycle();
        end
        @(negedge clk_i);
        check("idle_release", busy_o, 0);
        next_cycle();
        req_val_i = 2'b01; out_rdy_i = 1'b0;
        next_cycle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            check("full_hold", {busy_o, out_val_o, req_rdy_o, out_data_o}, {1'b1, 1'b1, 2'b00, D0});
            next_cycle();
        end
        out_rdy_i = 1'b1;
        @(negedge clk_i);
        check("full_resume", req_rdy_o, 2'b01);
        next_cycle();

        // Randomized run against the transaction model
        do_reset();
        stop_gen = 1'b0;
        m_busy = 1'b0; m_last = N - 1; m_tag = 0; m_beats = 0; m_idle = 0;
        for (int k = 0; k < N; k++) begin
            have[k] = 1'b0; gap[k] = 0; rem[k] = 0; seq[k] = 0; cur_d[k] = '0; cur_l[k] = 1'b0;
            exp_q[k].delete();
        end
        for (int c = 0; c < 4000; c++) begin
            if (c >= 3600) stop_gen = 1'b1;
            drive_producers((c < 1800) ? 0 : (c < 3600) ? 1 : 2, c[0]);
            @(negedge clk_i);
            model_step();
            next_cycle();
        end
        for (int k = 0; k < N; k++) begin
            check($sformatf("drain_q%0d", k), exp_q[k].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
